// File: rtl/rr_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_shared_reg_arbiter
//
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// N_REQ requesters compete to load the register. One requester is granted at
// a time. Its data slice is captured into Q at the end of the single GRANT
// cycle. The resource is then held for COOL_CYC cooldown cycles before the
// next arbitration.
//
// Ports
//   CLK      in   1              clock, all state changes on posedge
//   RST      in   1              synchronous reset, active-high
//   REQ      in   N_REQ          request vector, bit i = requester i
//   DATA_IN  in   N_REQ*WIDTH    packed data, slice i = DATA_IN[i*WIDTH +: WIDTH]
//   GNT      out  N_REQ          one-hot grant, high only in the GRANT cycle
//   GNT_ID   out  $clog2(N_REQ)  index of the current or most recent grantee
//   BUSY     out  1              high in GRANT and COOLDOWN
//   Q        out  WIDTH          shared register contents
//   Q_VALID  out  1              one-cycle pulse in the cycle after Q loads
// ---------------------------------------------------------------------------
module rr_shared_reg_arbiter #(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 8,
  parameter int COOL_CYC = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [N_REQ-1:0]           REQ,
  input  logic [N_REQ*WIDTH-1:0]     DATA_IN,
  output logic [N_REQ-1:0]           GNT,
  output logic [$clog2(N_REQ)-1:0]   GNT_ID,
  output logic                       BUSY,
  output logic [WIDTH-1:0]           Q,
  output logic                       Q_VALID
);

  localparam int ID_W = $clog2(N_REQ);
  // The cooldown counter runs 0 .. COOL_CYC-1, so $clog2(COOL_CYC) bits
  // suffice; keep at least one bit so the declaration stays legal.
  localparam int CNT_W = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
  localparam logic [CNT_W-1:0] COOL_LAST =
    (COOL_CYC > 0) ? CNT_W'(COOL_CYC - 1) : '0;
  // Pointer value after reset: the scan starts at (last+1) mod N_REQ = 0.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_COOLDOWN
  } state_t;

  state_t            state_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic [ID_W-1:0]   gnt_id_reg;
  logic              busy_reg;
  logic [WIDTH-1:0]  q_reg;
  logic              q_valid_reg;
  logic [ID_W-1:0]   last_reg;
  logic [CNT_W-1:0]  cool_cnt_reg;

  logic [WIDTH-1:0]  slice [N_REQ];
  logic [ID_W-1:0]   winner_next;
  logic [N_REQ-1:0]  winner_onehot_next;
  logic              req_any;

  // Unpack the flat data bus into one word per requester.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = DATA_IN[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin pick: first set request scanning upward from last+1 with
  // wrap. The loop walks from the farthest candidate to the nearest so the
  // nearest requester is the one left standing, with no early exit needed.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [ID_W-1:0]  last
  );
    logic [ID_W-1:0] pick;
    int              idx;
    pick = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (req[idx]) begin
        pick = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  assign req_any = |REQ;

  always_comb begin
    winner_next = rr_pick(REQ, last_reg);
  end

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign winner_onehot_next[gi] = (winner_next == ID_W'(gi));
    end
  endgenerate

  // Single registered FSM; every output is a register updated here.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      q_reg        <= '0;
      q_valid_reg  <= 1'b0;
      last_reg     <= LAST_RST;
      cool_cnt_reg <= '0;
    end else begin
      // Q_VALID is a pulse: only the GRANT branch raises it.
      q_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (req_any) begin
            gnt_reg    <= winner_onehot_next;
            gnt_id_reg <= winner_next;
            busy_reg   <= 1'b1;
            state_reg  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // REQ is deliberately not re-checked: the grantee committed its
          // data when it was granted.
          q_reg        <= slice[gnt_id_reg];
          q_valid_reg  <= 1'b1;
          last_reg     <= gnt_id_reg;
          gnt_reg      <= '0;
          cool_cnt_reg <= '0;
          if (COOL_CYC > 0) begin
            state_reg <= ST_COOLDOWN;
          end else begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        ST_COOLDOWN: begin
          // Requests are ignored here; they are seen again once in IDLE.
          if (cool_cnt_reg == COOL_LAST) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cool_cnt_reg <= cool_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  assign GNT     = gnt_reg;
  assign GNT_ID  = gnt_id_reg;
  assign BUSY    = busy_reg;
  assign Q       = q_reg;
  assign Q_VALID = q_valid_reg;

endmodule
